// File: rtl/cnu_sched.sv
// cnu_sched: row scheduler around an external two-pass min core.
// Each accepted row is turned into saturated magnitudes (padded with MAX),
// presented to the core for a first-minimum pass and a second-minimum pass,
// and the core results are held with sign and frame bookkeeping until consumed.
module cnu_sched #(
    parameter int BITS = 8,
    parameter int DMAX = 10,
    parameter int MAX  = 2**(BITS-1)-1,
    parameter int IDXW = $clog2(DMAX),
    parameter int ROWW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWW-1:0]        cfg_rows,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_x [DMAX],
    input  logic [IDXW:0]          in_deg,
    output logic                   cnu_sel,
    output logic signed [BITS-1:0] cnu_x [DMAX],
    input  logic signed [BITS-1:0] cnu_min1,
    input  logic signed [BITS-1:0] cnu_min2,
    input  logic [IDXW-1:0]        cnu_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-1:0]        out_min1,
    output logic [BITS-1:0]        out_min2,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_sgn,
    output logic [DMAX-1:0]        out_signs,
    output logic [ROWW-1:0]        out_row,
    output logic                   out_last
);

    localparam logic signed [BITS-1:0] MAX_V = BITS'(MAX);
    localparam logic [IDXW:0]          DMAX_V = (IDXW+1)'(DMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic                     accept;
    logic                     out_hs;
    logic [IDXW:0]            deg_c;
    logic signed [BITS-1:0]   mag_c [DMAX];
    logic [DMAX-1:0]          sign_c;
    logic [DMAX-1:0]          row_signs;
    logic                     row_sgn;
    logic [ROWW-1:0]          row_cnt;
    logic [ROWW-1:0]          row_inc;
    logic [ROWW-1:0]          row_next;
    logic [ROWW-1:0]          rows_lat;
    logic                     frame_start;

    // Magnitude with the most negative code saturating to MAX.
    function automatic logic signed [BITS-1:0] sat_mag(input logic signed [BITS-1:0] x);
        if (x[BITS-1] && (x[BITS-2:0] == '0)) begin
            return MAX_V;
        end else if (x[BITS-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    // Degrees above the slot count are treated as a full row.
    function automatic logic [IDXW:0] clip_deg(input logic [IDXW:0] d);
        return (d > DMAX_V) ? DMAX_V : d;
    endfunction

    // Per-slot magnitude and sign of the offered row; padded slots become MAX with sign 0.
    always_comb begin
        deg_c  = clip_deg(in_deg);
        sign_c = '0;
        for (int i = 0; i < DMAX; i++) begin
            mag_c[i] = MAX_V;
            if (i < int'(deg_c)) begin
                mag_c[i]  = sat_mag(in_x[i]);
                sign_c[i] = in_x[i][BITS-1];
            end
        end
    end

    // Next-state, handshake and core phase select.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = P0;
            end
            P0:   state_nx = P1;
            P1:   state_nx = HOLD;
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_nx = in_valid ? P0 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        cnu_sel = (state == P1);
        accept  = in_valid && in_ready;
        out_hs  = out_valid && out_ready;
        // Row number the accepted row will carry; row 0 marks a frame start.
        row_inc     = out_last ? '0 : row_cnt + 1'b1;
        row_next    = out_hs ? row_inc : row_cnt;
        frame_start = accept && (row_next == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Register the accepted row: magnitudes feed the core for both passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMAX; i++) cnu_x[i] <= '0;
            row_signs <= '0;
            row_sgn   <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < DMAX; i++) cnu_x[i] <= mag_c[i];
            row_signs <= sign_c;
            row_sgn   <= ^sign_c;
        end
    end

    // Row counter advances on each output handshake; frame size latched at row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            rows_lat <= ROWW'(1);
        end else begin
            row_cnt <= row_next;
            if (frame_start) rows_lat <= (cfg_rows == '0) ? ROWW'(1) : cfg_rows;
        end
    end

    // Capture core results at the end of the second pass and hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_min1  <= '0;
            out_min2  <= '0;
            out_idx   <= '0;
            out_sgn   <= 1'b0;
            out_signs <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (state == P1) begin
            out_valid <= 1'b1;
            out_min1  <= cnu_min1;
            out_min2  <= cnu_min2;
            out_idx   <= cnu_idx;
            out_sgn   <= row_sgn;
            out_signs <= row_signs;
            out_row   <= row_cnt;
            out_last  <= (row_cnt == rows_lat - 1'b1);
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule
